// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Byte-addressed, little-endian data/instruction memory endpoint for the
// single-cycle RV32I controller. One store and one load are accepted every
// cycle. Stores commit at the rising edge. Loads are registered with one cycle
// of latency. When the store and the load hit the same word in one cycle, the
// load sees the freshly written bytes (write-first, resolved per byte lane).
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words; must be a power of two, >= 2
//   INIT_FILE     image name; contents are left untouched
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (outputs only, not storage)
//   write_mem      store strobe for this cycle
//   funct3         access size/sign shared by both ports:
//                  000 b, 001 h, 010 w, 100 bu, 101 hu
//   write_address  byte address of the store
//   write_data     store data, low 8/16/32 bits used
//   read_address   byte address of the load
//   read_data      sized and extended load result (0 for an illegal load)
//   read_valid     read_data holds a result produced since reset
//   access_err     sticky flag for misaligned or illegal accesses
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        access_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ---------------------------------------------------------------------------
  // Address decode. Bits above the word index are dropped so that addresses
  // wrap modulo the memory size.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic [AW-1:0] r_idx;
  logic [1:0]    w_lane;
  logic [1:0]    r_lane;
  logic          unused_addr_bits;

  assign w_idx  = write_address[AW+1:2];
  assign r_idx  = read_address[AW+1:2];
  assign w_lane = write_address[1:0];
  assign r_lane = read_address[1:0];

  assign unused_addr_bits = ^{write_address[31:AW+2], read_address[31:AW+2]};

  // ---------------------------------------------------------------------------
  // Store decode: byte enables plus the store data replicated onto every lane
  // it could land on, so lane b always takes st_lanes[8*b +: 8].
  // ---------------------------------------------------------------------------
  logic [3:0]  st_be;
  logic [31:0] st_lanes;
  logic        st_err;
  logic [3:0]  wr_be;

  always_comb begin
    st_be    = 4'b0000;
    st_lanes = write_data;
    st_err   = 1'b0;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << w_lane;
        st_lanes = {4{write_data[7:0]}};
      end
      F3_H: begin
        st_lanes = {2{write_data[15:0]}};
        if (w_lane[0]) begin
          st_err = 1'b1;
        end else begin
          st_be = w_lane[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: begin
        if (w_lane != 2'b00) begin
          st_err = 1'b1;
        end else begin
          st_be = 4'b1111;
        end
      end
      default: begin
        st_err = 1'b1;
      end
    endcase
    // Without a strobe nothing is written and nothing can be illegal.
    if (!write_mem) begin
      st_be  = 4'b0000;
      st_err = 1'b0;
    end
  end

  // A store sampled while reset is held is dropped, but the array itself is
  // never cleared.
  assign wr_be = rst_n ? st_be : 4'b0000;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_q[w_idx][8*b +: 8] <= st_lanes[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path with per-lane write-first forwarding: a lane being written this
  // cycle in the same word takes the store byte, every other lane takes the
  // stored byte.
  // ---------------------------------------------------------------------------
  logic [31:0] mem_rd_word;
  logic [31:0] fwd_word;
  logic        same_word;

  assign mem_rd_word = mem_q[r_idx];
  assign same_word   = (w_idx == r_idx);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      assign fwd_word[8*gi +: 8] = (wr_be[gi] && same_word) ? st_lanes[8*gi +: 8]
                                                             : mem_rd_word[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ld_data;
  logic        ld_err;

  always_comb begin
    sel_byte = fwd_word[7:0];
    case (r_lane)
      2'd0: sel_byte = fwd_word[7:0];
      2'd1: sel_byte = fwd_word[15:8];
      2'd2: sel_byte = fwd_word[23:16];
      2'd3: sel_byte = fwd_word[31:24];
      default: sel_byte = fwd_word[7:0];
    endcase
    sel_half = r_lane[1] ? fwd_word[31:16] : fwd_word[15:0];
  end

  always_comb begin
    ld_data = 32'h0000_0000;
    ld_err  = 1'b0;
    case (funct3)
      F3_B:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU: ld_data = {24'h00_0000, sel_byte};
      F3_H: begin
        if (r_lane[0]) begin
          ld_err = 1'b1;
        end else begin
          ld_data = {{16{sel_half[15]}}, sel_half};
        end
      end
      F3_HU: begin
        if (r_lane[0]) begin
          ld_err = 1'b1;
        end else begin
          ld_data = {16'h0000, sel_half};
        end
      end
      F3_W: begin
        if (r_lane != 2'b00) begin
          ld_err = 1'b1;
        end else begin
          ld_data = fwd_word;
        end
      end
      default: begin
        ld_err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [31:0] read_data_q;
  logic [31:0] read_data_d;
  logic        read_valid_q;
  logic        access_err_q;
  logic        access_err_d;

  assign read_data_d  = ld_data;
  assign access_err_d = access_err_q | ld_err | st_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= 32'h0000_0000;
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= 1'b1;
      access_err_q <= access_err_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder: a directed vector table, hand-written
// reset / error / wrap sequences, and randomized traffic compared against a
// byte-array reference model.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default depth)
  logic        rst_n;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_valid;
  logic        access_err;

  // Small instance used for the address wrap check
  logic        s_write_mem;
  logic [2:0]  s_funct3;
  logic [31:0] s_write_address;
  logic [31:0] s_write_data;
  logic [31:0] s_read_address;
  logic [31:0] s_read_data;
  logic        s_read_valid;
  logic        s_access_err;

  mem_responder #(.DEPTH_WORDS(4096)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .access_err    (access_err)
  );

  mem_responder #(.DEPTH_WORDS(16)) dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_mem     (s_write_mem),
    .funct3        (s_funct3),
    .write_address (s_write_address),
    .write_data    (s_write_data),
    .read_address  (s_read_address),
    .read_data     (s_read_data),
    .read_valid    (s_read_valid),
    .access_err    (s_access_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of traffic and return just after the sampling edge.
  task automatic apply(input bit we, input logic [2:0] f3, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [31:0] ra);
    write_mem     = we;
    funct3        = f3;
    write_address = wa;
    write_data    = wd;
    read_address  = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    write_mem = 1'b0;
    funct3    = 3'b010;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string nm, input bit we, input logic [2:0] f3,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra, input logic [31:0] exp_rd,
                         input bit exp_err);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.wa = wa; v.wd = wd;
    v.ra = ra; v.exp_rd = exp_rd; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a plain byte array covering a private region, with the
  // access rules expressed as size/alignment arithmetic.
  // ---------------------------------------------------------------------------
  localparam int RBASE = 'h100;
  localparam int RSIZE = 256;

  logic [7:0] ref_mem [RSIZE];
  bit         ref_err;

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic bit store_ok(input logic [2:0] f3, input logic [31:0] a);
    return (f3 inside {3'b000, 3'b001, 3'b010}) && is_aligned(f3, a);
  endfunction

  function automatic bit load_ok(input logic [2:0] f3, input logic [31:0] a);
    return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && is_aligned(f3, a);
  endfunction

  function automatic int ref_off(input logic [31:0] a);
    return int'(a & 32'h3FFF) - RBASE;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int off;
    off = ref_off(a);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[off + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int     n;
    int     off;
    if (!load_ok(f3, a)) return 32'h0;
    n   = acc_size(f3);
    off = ref_off(a);
    v   = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[off + i]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] f3, input bit force_align);
    int off;
    off = $urandom_range(0, RSIZE - 1);
    if (force_align || $urandom_range(0, 3) != 0) off = off - (off % acc_size(f3));
    // Random bits above the decoded range must be ignored.
    return 32'(RBASE + off) + (32'($urandom_range(0, 7)) << 14);
  endfunction

  task automatic random_phase(input int count, input bit legal_only, input int tag);
    bit          we;
    logic [2:0]  f3;
    logic [31:0] wa, wd, ra, exp_rd;
    for (int k = 0; k < count; k++) begin
      if (legal_only) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      wa = rand_addr(f3, legal_only && f3[2] == 1'b0);
      ra = rand_addr(f3, legal_only);
      wd = $urandom;
      we = ($urandom_range(0, 3) != 0);
      if (legal_only && f3[2]) we = 1'b0;
      // Store applies before the load in the same cycle (write-first).
      if (we) begin
        if (store_ok(f3, wa)) model_store(f3, wa, wd);
        else ref_err = 1'b1;
      end
      if (!load_ok(f3, ra)) ref_err = 1'b1;
      exp_rd = model_load(f3, ra);
      apply(we, f3, wa, wd, ra);
      $display("rnd%0d[%0d] we=%0b f3=%03b wa=%08h ra=%08h rd=%08h err=%0b",
               tag, k, we, f3, wa, ra, read_data, access_err);
      check("rnd_read_data", read_data, exp_rd);
      check("rnd_access_err", {31'b0, access_err}, {31'b0, ref_err});
      check("rnd_read_valid", {31'b0, read_valid}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;

    rst_n         = 1'b1;
    write_mem     = 1'b0;
    funct3        = 3'b010;
    write_address = 32'h0;
    write_data    = 32'h0;
    read_address  = 32'h0;
    s_write_mem     = 1'b0;
    s_funct3        = 3'b010;
    s_write_address = 32'h0;
    s_write_data    = 32'h0;
    s_read_address  = 32'h0;
    ref_err         = 1'b0;

    // Reset state
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("reset: rd=%08h valid=%0b err=%0b", read_data, read_valid, access_err);
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", {31'b0, read_valid}, 32'd0);
    check("reset_access_err", {31'b0, access_err}, 32'd0);
    rst_n = 1'b1;

    // Directed table
    add_vec("sw_fwd_10",    1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 0);
    add_vec("lw_10",        0, 3'b010, 32'h0,  32'h0,        32'h10, 32'hDEADBEEF, 0);
    add_vec("sw_20",        1, 3'b010, 32'h20, 32'h80FF7F01, 32'h20, 32'h80FF7F01, 0);
    add_vec("lb_23",        0, 3'b000, 32'h0,  32'h0,        32'h23, 32'hFFFFFF80, 0);
    add_vec("lbu_23",       0, 3'b100, 32'h0,  32'h0,        32'h23, 32'h00000080, 0);
    add_vec("lh_22",        0, 3'b001, 32'h0,  32'h0,        32'h22, 32'hFFFF80FF, 0);
    add_vec("lhu_22",       0, 3'b101, 32'h0,  32'h0,        32'h22, 32'h000080FF, 0);
    add_vec("lb_21",        0, 3'b000, 32'h0,  32'h0,        32'h21, 32'h0000007F, 0);
    add_vec("sw_30",        1, 3'b010, 32'h30, 32'h11223344, 32'h30, 32'h11223344, 0);
    add_vec("sb_31_fwd",    1, 3'b000, 32'h31, 32'h123456AA, 32'h31, 32'hFFFFFFAA, 0);
    add_vec("lw_30_merge",  0, 3'b010, 32'h0,  32'h0,        32'h30, 32'h1122AA44, 0);
    add_vec("sh_32_oldlow", 1, 3'b001, 32'h32, 32'h9999BEEF, 32'h30, 32'hFFFFAA44, 0);
    add_vec("lw_30_sh",     0, 3'b010, 32'h0,  32'h0,        32'h30, 32'hBEEFAA44, 0);
    add_vec("sw_50",        1, 3'b010, 32'h50, 32'h0BADF00D, 32'h50, 32'h0BADF00D, 0);
    add_vec("sw_40",        1, 3'b010, 32'h40, 32'h01020304, 32'h40, 32'h01020304, 0);
    add_vec("sw_42_misal",  1, 3'b010, 32'h42, 32'hCAFEF00D, 32'h40, 32'h01020304, 1);
    add_vec("lw_40_sticky", 0, 3'b010, 32'h0,  32'h0,        32'h40, 32'h01020304, 1);
    add_vec("lh_01_misal",  0, 3'b001, 32'h0,  32'h0,        32'h01, 32'h00000000, 1);
    add_vec("st_f3_100",    1, 3'b100, 32'h40, 32'h000000FF, 32'h40, 32'h00000004, 1);
    add_vec("lw_40_after",  0, 3'b010, 32'h0,  32'h0,        32'h40, 32'h01020304, 1);
    add_vec("lw_4010_wrap", 0, 3'b010, 32'h0,  32'h0,        32'h4010, 32'hDEADBEEF, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].we, tbl[i].f3, tbl[i].wa, tbl[i].wd, tbl[i].ra);
      $display("vec %-13s we=%0b f3=%03b wa=%08h ra=%08h rd=%08h err=%0b",
               tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].wa, tbl[i].ra, read_data, access_err);
      check({tbl[i].name, "_rd"}, read_data, tbl[i].exp_rd);
      check({tbl[i].name, "_err"}, {31'b0, access_err}, {31'b0, tbl[i].exp_err});
      check({tbl[i].name, "_valid"}, {31'b0, read_valid}, 32'd1);
    end

    // Reset asserted mid-cycle while a store is presented
    write_mem     = 1'b1;
    funct3        = 3'b010;
    write_address = 32'h50;
    write_data    = 32'h00000055;
    read_address  = 32'h50;
    rst_n         = 1'b0;
    #1;
    $display("midreset: rd=%08h valid=%0b err=%0b", read_data, read_valid, access_err);
    check("midrst_read_data", read_data, 32'h0);
    check("midrst_read_valid", {31'b0, read_valid}, 32'd0);
    check("midrst_access_err", {31'b0, access_err}, 32'd0);
    @(posedge clk);
    #1;
    write_mem = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("release_valid_low", {31'b0, read_valid}, 32'd0);
    @(posedge clk);
    #1;
    $display("after release: lw 50 rd=%08h valid=%0b err=%0b", read_data, read_valid, access_err);
    check("release_lw_50", read_data, 32'h0BADF00D);
    check("release_valid_high", {31'b0, read_valid}, 32'd1);
    check("release_err_clear", {31'b0, access_err}, 32'd0);

    // Load-side misalignment alone
    apply(0, 3'b010, 32'h0, 32'h0, 32'h10);
    check("pre_lh_lw_10", read_data, 32'hDEADBEEF);
    apply(0, 3'b001, 32'h0, 32'h0, 32'h01);
    $display("lh 01: rd=%08h err=%0b", read_data, access_err);
    check("lh_01_rd", read_data, 32'h0);
    check("lh_01_err", {31'b0, access_err}, 32'd1);
    do_reset();

    // Load with reserved funct3
    apply(0, 3'b010, 32'h0, 32'h0, 32'h10);
    check("pre_f3_lw_10", read_data, 32'hDEADBEEF);
    apply(0, 3'b011, 32'h0, 32'h0, 32'h10);
    $display("f3=011 load: rd=%08h err=%0b", read_data, access_err);
    check("f3_011_rd", read_data, 32'h0);
    check("f3_011_err", {31'b0, access_err}, 32'd1);
    do_reset();

    // Store-side misalignment alone, load stays legal
    apply(1, 3'b001, 32'h41, 32'h0000FFFF, 32'h40);
    $display("sh 41: rd=%08h err=%0b", read_data, access_err);
    check("sh_41_lh_40", read_data, 32'h00000304);
    check("sh_41_err", {31'b0, access_err}, 32'd1);
    apply(0, 3'b010, 32'h0, 32'h0, 32'h40);
    check("sh_41_word_kept", read_data, 32'h01020304);
    do_reset();

    // Wrap-around on the 16-word instance
    s_write_mem     = 1'b1;
    s_funct3        = 3'b010;
    s_write_address = 32'h44;
    s_write_data    = 32'h12345678;
    s_read_address  = 32'h0;
    @(posedge clk);
    #1;
    s_write_mem    = 1'b0;
    s_read_address = 32'h04;
    @(posedge clk);
    #1;
    $display("wrap16: lw 04 rd=%08h err=%0b", s_read_data, s_access_err);
    check("wrap16_lw_04", s_read_data, 32'h12345678);
    check("wrap16_err", {31'b0, s_access_err}, 32'd0);
    s_read_address = 32'h3C4;
    @(posedge clk);
    #1;
    check("wrap16_lw_3c4", s_read_data, 32'h12345678);
    s_read_address = 32'h0;

    // Randomized traffic: preload the model region, then legal-only traffic,
    // then unrestricted traffic after a fresh reset.
    for (int k = 0; k < RSIZE / 4; k++) begin
      wd = $urandom;
      model_store(3'b010, 32'(RBASE + 4 * k), wd);
      apply(1, 3'b010, 32'(RBASE + 4 * k), wd, 32'(RBASE));
    end
    ref_err = 1'b0;
    random_phase(200, 1'b1, 0);
    do_reset();
    ref_err = 1'b0;
    random_phase(200, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
